// File: rtl/mem_bus_arbiter.sv
// Byte-serial controller for the shared 8-bit memory port (instruction fetch vs load/store buffer).
// Define MEM_ARB_RR_EN for round-robin arbitration; by default the LSB has fixed priority over fetch.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              if_en,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [31:0]       if_data,
  input  logic              lsb_en,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [3:0]        lsb_type,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_rdy,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n_bytes;
  logic [2:0]        cnt;          // byte index currently on mem_a
  logic [2:0]        cnt_inc;
  logic              primed;       // mem_din holds the byte for index cnt-1
  logic              replay;       // a stall swallowed a pending capture
  logic              gnt_lsb;
  logic              ld_unsigned;
  logic [1:0]        ld_size;
  logic [23:0]       wbuf;
  logic [31:0]       rbuf, rd_merged;
  logic [1:0]        cap_lane;
  logic              wr_q;
  logic              lsb_ok, prio_lsb, pick_lsb, take;
  logic [ADDR_W-1:0] sel_addr;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   return {{24{~uns & w[7]}}, w[7:0]};
      2'b01:   return {{16{~uns & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] byte_addr(input logic [ADDR_W-1:0] b, input logic [2:0] idx);
    return 32'(b + ADDR_W'(idx));
  endfunction

  // UART stores are held off entirely while the output buffer is full.
  assign lsb_ok   = lsb_en && !(lsb_type[3] && lsb_addr[17:16] == 2'b11 && io_buffer_full);
  assign pick_lsb = lsb_ok && (!if_en || prio_lsb);
  assign sel_addr = pick_lsb ? lsb_addr : if_addr;
  assign cnt_inc  = cnt + 3'd1;
  assign cap_lane = cnt[1:0] - 2'd1;
  assign mem_wr   = wr_q & rdy_in;

`ifdef MEM_ARB_RR_EN
  logic last_lsb;

  assign prio_lsb = !last_lsb;

  always_ff @(posedge clk_in) begin
    if (rst_in)    last_lsb <= 1'b0;
    else if (take) last_lsb <= pick_lsb;
  end
`else
  assign prio_lsb = 1'b1;
`endif

  always_comb begin
    rd_merged = rbuf;
    rd_merged[{cap_lane, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_next = state;
    take       = 1'b0;
    if (rdy_in) begin
      case (state)
        IDLE:
          if (!flush && (if_en || lsb_ok)) begin
            take       = 1'b1;
            state_next = (pick_lsb && lsb_type[3]) ? WRITE : READ;
          end
        READ:
          if (flush)                                      state_next = IDLE;
          else if (!replay && primed && cnt == n_bytes)   state_next = DONE;
        WRITE:
          if (cnt == n_bytes - 3'd1)                      state_next = DONE;
        default:                                          state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_a       <= '0;
      mem_dout    <= '0;
      wr_q        <= 1'b0;
      if_rdy      <= 1'b0;
      lsb_rdy     <= 1'b0;
      if_data     <= '0;
      lsb_rdata   <= '0;
      base        <= '0;
      n_bytes     <= 3'd4;
      cnt         <= '0;
      primed      <= 1'b0;
      replay      <= 1'b0;
      gnt_lsb     <= 1'b0;
      ld_unsigned <= 1'b0;
      ld_size     <= '0;
      wbuf        <= '0;
      rbuf        <= '0;
    end else if (!rdy_in) begin
      if (state == READ && primed) replay <= 1'b1;
    end else begin
      if_rdy  <= 1'b0;
      lsb_rdy <= 1'b0;
      replay  <= 1'b0;
      case (state)
        IDLE:
          if (take) begin
            gnt_lsb     <= pick_lsb;
            base        <= sel_addr;
            mem_a       <= 32'(sel_addr);
            n_bytes     <= pick_lsb ? size_bytes(lsb_type[1:0]) : 3'd4;
            ld_size     <= pick_lsb ? lsb_type[1:0] : 2'b10;
            ld_unsigned <= lsb_type[2];
            cnt         <= '0;
            primed      <= 1'b0;
            wr_q        <= pick_lsb && lsb_type[3];
            if (pick_lsb && lsb_type[3]) begin
              mem_dout <= lsb_wdata[7:0];
              wbuf     <= lsb_wdata[31:8];
            end
          end
        READ:
          if (!flush) begin
            if (replay) begin
              // Re-drive the byte whose response was lost and refill the one-cycle pipe.
              cnt    <= cnt - 3'd1;
              primed <= 1'b0;
              mem_a  <= byte_addr(base, cnt - 3'd1);
            end else begin
              if (primed) rbuf <= rd_merged;
              if (primed && cnt == n_bytes) begin
                if (gnt_lsb) begin
                  lsb_rdata <= extend(rd_merged, ld_size, ld_unsigned);
                  lsb_rdy   <= 1'b1;
                end else begin
                  if_data <= rd_merged;
                  if_rdy  <= 1'b1;
                end
              end else begin
                primed <= 1'b1;
                cnt    <= cnt_inc;
                if (cnt_inc < n_bytes) mem_a <= byte_addr(base, cnt_inc);
              end
            end
          end
        WRITE:
          if (cnt == n_bytes - 3'd1) begin
            wr_q      <= 1'b0;
            lsb_rdata <= '0;
            lsb_rdy   <= 1'b1;
          end else begin
            cnt      <= cnt_inc;
            mem_a    <= byte_addr(base, cnt_inc);
            mem_dout <= wbuf[7:0];
            wbuf     <= {8'h00, wbuf[23:8]};
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: a byte memory model answers reads one cycle after the address.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        if_en, if_rdy;
  logic [31:0] if_addr, if_data;
  logic        lsb_en, lsb_rdy;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [3:0]  lsb_type;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic [7:0]  mem [0:4095];
  logic [31:0] alog[$], wdat[$], wadr[$];

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  mem_bus_arbiter #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_addr(lsb_addr), .lsb_type(lsb_type), .lsb_wdata(lsb_wdata),
    .lsb_rdy(lsb_rdy), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always @(posedge clk_in) mem_din <= mem[mem_a[11:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Runs one request (enable already raised) until its rdy or the cycle budget; lat = -1 on no rdy.
  task automatic do_txn(input bit is_lsb, input int max, input int flush_at,
                        output int lat, output int nwr);
    lat = -1;
    nwr = 0;
    alog.delete();
    wdat.delete();
    wadr.delete();
    for (int k = 1; k <= max; k++) begin
      tick();
      flush = 1'b0;
      alog.push_back(mem_a);
      if (mem_wr) begin
        nwr++;
        wdat.push_back(32'(mem_dout));
        wadr.push_back(mem_a);
      end
      if (k == flush_at) begin
        flush = 1'b1;
        if_en = 1'b0;
      end
      if (is_lsb ? lsb_rdy : if_rdy) begin
        lat = k;
        break;
      end
    end
    flush  = 1'b0;
    if_en  = 1'b0;
    lsb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nwr, n, cnt_wr, cnt_rdy;
    logic [3:0]  exp_lsb;
    logic [31:0] ld_addr [5] = '{32'h180, 32'h180, 32'h180, 32'h180, 32'h102};
    logic [3:0]  ld_type [5] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010};
    logic [31:0] ld_exp  [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0,
                                 32'h0000_80F0, 32'hAB7F_0010};
    int          ld_lat  [5] = '{3, 3, 4, 4, 6};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
    mem[12'h104] = 8'h7F; mem[12'h105] = 8'hAB; mem[12'h180] = 8'hF0; mem[12'h181] = 8'h80;

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_addr = '0; lsb_en = 1'b0; lsb_addr = '0; lsb_type = '0; lsb_wdata = '0;
    repeat (3) tick();
    check("rst_mem_a",     mem_a,            32'h0);
    check("rst_mem_dout",  32'(mem_dout),    32'h0);
    check("rst_mem_wr",    32'(mem_wr),      32'h0);
    check("rst_if_rdy",    32'(if_rdy),      32'h0);
    check("rst_lsb_rdy",   32'(lsb_rdy),     32'h0);
    check("rst_if_data",   if_data,          32'h0);
    check("rst_lsb_rdata", lsb_rdata,        32'h0);
    rst_in = 1'b0;
    tick();

    // Word fetch.
    if_addr = 32'h100; if_en = 1'b1;
    do_txn(1'b0, 20, 0, lat, nwr);
    check("fetch_lat",    32'(lat),      32'd6);
    check("fetch_data",   if_data,       32'h0010_0513);
    check("fetch_nwr",    32'(nwr),      32'd0);
    check("fetch_a0",     alog[0],       32'h100);
    check("fetch_a1",     alog[1],       32'h101);
    check("fetch_a3",     alog[3],       32'h103);
    check("fetch_no_lsb", 32'(lsb_rdy),  32'h0);
    tick();

    // Loads: sign/zero extension and a misaligned word.
    for (int i = 0; i < 5; i++) begin
      lsb_addr = ld_addr[i]; lsb_type = ld_type[i]; lsb_en = 1'b1;
      do_txn(1'b1, 20, 0, lat, nwr);
      check($sformatf("load%0d_data", i), lsb_rdata, ld_exp[i]);
      check($sformatf("load%0d_lat", i),  32'(lat),  32'(ld_lat[i]));
      tick();
    end

    // Half store.
    lsb_addr = 32'h200; lsb_wdata = 32'hAABB_CCDD; lsb_type = 4'b1001; lsb_en = 1'b1;
    do_txn(1'b1, 20, 0, lat, nwr);
    check("sh_lat",   32'(lat),  32'd3);
    check("sh_nwr",   32'(nwr),  32'd2);
    check("sh_b0",    wdat[0],   32'hDD);
    check("sh_b1",    wdat[1],   32'hCC);
    check("sh_a0",    wadr[0],   32'h200);
    check("sh_a1",    wadr[1],   32'h201);
    check("sh_rdata", lsb_rdata, 32'h0);
    tick();

    // UART store held while the buffer is full.
    lsb_addr = 32'h3_0000; lsb_wdata = 32'h41; lsb_type = 4'b1000;
    io_buffer_full = 1'b1; lsb_en = 1'b1;
    cnt_wr = 0; cnt_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (mem_wr)  cnt_wr++;
      if (lsb_rdy) cnt_rdy++;
    end
    check("uart_stall_wr",  32'(cnt_wr),  32'd0);
    check("uart_stall_rdy", 32'(cnt_rdy), 32'd0);
    io_buffer_full = 1'b0;
    tick();
    check("uart_wr",   32'(mem_wr),   32'h1);
    check("uart_a",    mem_a,         32'h3_0000);
    check("uart_dout", 32'(mem_dout), 32'h41);
    tick();
    check("uart_rdy",  32'(lsb_rdy),  32'h1);
    lsb_en = 1'b0;
    tick();

    // Global stall in the middle of a word read; the lost byte must be re-fetched.
    if_addr = 32'h102; if_en = 1'b1;
    repeat (3) tick();
    rdy_in = 1'b0;
    repeat (2) tick();
    rdy_in = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (if_rdy) begin
        lat = k;
        break;
      end
    end
    if_en = 1'b0;
    check("rdystall_done", 32'(lat > 0), 32'h1);
    check("rdystall_data", if_data,      32'hAB7F_0010);
    tick();

    // Global stall during a store forces mem_wr low and reissues the byte.
    lsb_addr = 32'h210; lsb_wdata = 32'h5A; lsb_type = 4'b1000; lsb_en = 1'b1;
    tick();
    check("wstall_wr_on",   32'(mem_wr), 32'h1);
    rdy_in = 1'b0;
    #1;
    check("wstall_wr_off",  32'(mem_wr), 32'h0);
    tick();
    check("wstall_wr_hold", 32'(mem_wr), 32'h0);
    check("wstall_a_hold",  mem_a,       32'h210);
    rdy_in = 1'b1;
    #1;
    check("wstall_wr_back", 32'(mem_wr), 32'h1);
    tick();
    check("wstall_rdy",     32'(lsb_rdy), 32'h1);
    lsb_en = 1'b0;
    tick();

    // Contention: both requesters held high; last grant so far went to the LSB.
`ifdef MEM_ARB_RR_EN
    exp_lsb = 4'b1010;
`else
    exp_lsb = 4'b1111;
`endif
    if_addr = 32'h100; lsb_addr = 32'h180; lsb_type = 4'b0100;
    if_en = 1'b1; lsb_en = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      tick();
      if (if_rdy || lsb_rdy) begin
        check($sformatf("cont%0d_winner", n), 32'(lsb_rdy), 32'(exp_lsb[n]));
        if (lsb_rdy) check($sformatf("cont%0d_ldata", n), lsb_rdata, 32'h0000_00F0);
        else         check($sformatf("cont%0d_fdata", n), if_data,   32'h0010_0513);
        n++;
      end
    end
    check("cont_count", 32'(n), 32'd4);
    if_en = 1'b0; lsb_en = 1'b0;
    repeat (2) tick();

    // Flush while fetch byte 2 is on the bus.
    if_addr = 32'h100; if_en = 1'b1;
    do_txn(1'b0, 8, 3, lat, nwr);
    check("flushf_no_rdy", 32'(lat), 32'hFFFF_FFFF);
    check("flushf_nwr",    32'(nwr), 32'd0);
    check("flushf_a3",     alog[3],  32'h102);
    check("flushf_a4",     alog[4],  32'h102);

    // A request presented together with flush is ignored for that cycle.
    lsb_addr = 32'h180; lsb_type = 4'b0100; lsb_en = 1'b1; flush = 1'b1;
    do_txn(1'b1, 20, 0, lat, nwr);
    check("flush_idle_lat",  32'(lat), 32'd4);
    check("flush_idle_data", lsb_rdata, 32'h0000_00F0);
    tick();

    // Flush during a word store does not abort it.
    lsb_addr = 32'h300; lsb_wdata = 32'h1122_3344; lsb_type = 4'b1010; lsb_en = 1'b1;
    do_txn(1'b1, 20, 2, lat, nwr);
    check("flushw_lat", 32'(lat), 32'd5);
    check("flushw_nwr", 32'(nwr), 32'd4);
    check("flushw_b0",  wdat[0],  32'h44);
    check("flushw_b1",  wdat[1],  32'h33);
    check("flushw_b2",  wdat[2],  32'h22);
    check("flushw_b3",  wdat[3],  32'h11);
    check("flushw_a3",  wadr[3],  32'h303);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Byte-serial controller for the single 8-bit external memory port. It shares the port between two requesters: the instruction-fetch path (word reads on icache miss) and the load/store buffer (byte/half/word loads and stores). It sequences multi-byte transfers, sign- or zero-extends load results, holds UART stores while the output buffer is full, and aborts speculative reads on pipeline flush. It sits between the fetch/LSB units and the top-level memory pins.

## Interface
Parameters:
- ADDR_W, 32, width of request addresses; only [17:0] reach memory.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global ready; when low, all state freezes.
- flush  in  1  mispredict flush; aborts pending or in-flight reads.
- if_en  in  1  fetch request; held high until if_rdy.
- if_addr  in  32  fetch address; the block fetches 4 bytes.
- if_rdy  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  little-endian word.
- lsb_en  in  1  LSB request; held high until lsb_rdy.
- lsb_addr  in  32  access address.
- lsb_type  in  4  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load; [3] store.
- lsb_wdata  in  32  store data; the low bytes are used.
- lsb_rdy  out  1  one-cycle pulse; the access is complete.
- lsb_rdata  out  32  extended load result; 0 for stores.
- mem_din  in  8  read byte; returned the cycle after the address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 means write.
- io_buffer_full  in  1  UART buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE behaviour:
  - Samples the requests and picks a grant.
  - Latches the address, byte count N (1/2/4), kind and store data.
  - Goes to READ or WRITE.
- READ:
  - Cycle i (0..N-1): drives mem_a = base+i, mem_wr = 0.
  - Cycle i+1: captures mem_din into byte lane i.
  - After the capture of byte N-1, goes to DONE.
- WRITE:
  - Cycle i: drives mem_a = base+i, mem_dout = byte i, mem_wr = 1.
  - After byte N-1, goes to DONE.
- DONE:
  - Pulses the granted requester's rdy for exactly one cycle, with the result on the data bus.
  - Returns to IDLE.
  - A new grant is not taken in the same cycle.
- Load extension:
  - Byte: signed fills bits [31:8] with bit 7; unsigned fills with 0.
  - Half: signed fills bits [31:16] with bit 15; unsigned fills with 0.
  - Word: no extension.
- Address arithmetic is 32-bit modulo. No alignment check; misaligned accesses are done byte by byte.
- IO stall: a store with lsb_addr[17:16] = 2'b11 waits in IDLE, not granted, while io_buffer_full = 1.
- Flush:
  - An in-flight READ returns to IDLE with no rdy pulse.
  - Pending if_en and lsb_en are ignored in that cycle.
  - An in-flight WRITE always completes, since stores are already committed, and still pulses lsb_rdy.
- rdy_in low:
  - State, counters and captured bytes hold.
  - mem_wr is forced to 0.
  - The in-flight byte index is reissued when rdy_in returns.
- Reset values: mem_a = 0, mem_dout = 0, mem_wr = 0, if_rdy = 0, lsb_rdy = 0, if_data = 0, lsb_rdata = 0, state IDLE, last-grant = fetch.

## Timing
- Read latency: if_en/lsb_en sampled in cycle 0 gives rdy in cycle N+2 (word fetch: cycle 6).
- Write latency: store sampled in cycle 0 gives lsb_rdy in cycle N+1.
- Back-to-back: the next grant is sampled in the cycle after the rdy pulse. The minimum gap between transactions is 1 idle cycle.
- The port is idle (mem_wr = 0, mem_a holds) in IDLE and DONE.
- Requesters must not drop en or change request fields before their rdy. A changed request is undefined except under flush.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - When both request, the one not granted last wins.
  - last-grant updates on every grant.
- MEM_ARB_RR_EN undefined:
  - Fixed priority; the LSB always wins over fetch.
  - last-grant is unused.

## Test plan
- **Fetch word:** if_addr = 0x100 with memory 0x13,0x05,0x10,0x00 → mem_a = 0x100..0x103, no writes, if_rdy in cycle 6 with if_data = 0x00100513.
- **Signed byte load:** lsb_type = 0000, memory 0xF0 → lsb_rdy in cycle 3 with lsb_rdata = 0xFFFFFFF0. Repeat with lsb_type = 0100 → 0x000000F0.
- **Half store:** lsb_addr = 0x200, wdata = 0xAABBCCDD, type 1001 → mem_wr high for 2 cycles writing 0xDD then 0xCC; lsb_rdy in cycle 3.
- **UART stall:** store to 0x30000 with io_buffer_full = 1 for 10 cycles → no mem_wr during the stall; the byte is written in the first cycle after full drops.
- **Contention:**
  - Both requesters high continuously, with RR → grants alternate LSB/fetch.
  - Without RR → the LSB wins every time.
- **Flush:**
  - Flush at fetch byte 2 → no if_rdy, IDLE the next cycle.
  - Flush during a word store → all 4 bytes written and lsb_rdy pulses.
